edge_det_axil_regs: RTL and testbench
=====================================

Name: edge_det_axil_regs

Overview:
AXI4-Lite slave register file that answers the bus master and controls the edge-detection core. It holds the threshold and image-size configuration, produces a start pulse for the core, captures the core's done event, and raises an interrupt. It sits between the AXI interconnect (the S00_AXI port) and the edge-detection datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, byte address width; bits [4:2] select the register; any bit above [4:0] set decodes as unmapped

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
core_start  out  1  one-cycle start pulse
core_threshold  out  8  THRESH[7:0]
core_width  out  16  IMG_SIZE[15:0]
core_height  out  16  IMG_SIZE[31:16]
core_busy  in  1  core is processing
core_done  in  1  one-cycle completion pulse
irq  out  1  level interrupt

Behaviour:
- Reset: all ready and valid outputs 0, BRESP/RRESP 0, RDATA 0, all registers 0, core_start 0, irq 0.
- Register map:
  - 0x00 CTRL: bit0 START writes a pulse and reads 0; bit1 IRQ_EN is RW; other bits read 0.
  - 0x04 THRESH: [7:0] RW; other bits read 0.
  - 0x08 IMG_SIZE: [31:0] RW.
  - 0x0C STATUS: bit0 BUSY is RO and reflects core_busy; bit1 DONE is sticky and cleared by writing 1 to it.
  - 0x10: see Optional Feature.
- Write channel:
  - AWREADY is high when no AW is latched and BVALID=0. WREADY follows the same rule for W.
  - AW and W are accepted independently in any order and latched.
  - The write commits in the cycle after both are latched. Byte lanes follow WSTRB.
  - In that same cycle BVALID rises. BVALID is held with BRESP stable until BREADY=1.
  - No new AW or W is accepted while BVALID=1.
- Read channel:
  - ARREADY is high when RVALID=0.
  - On the AR handshake, RDATA/RRESP are registered and RVALID rises the next cycle.
  - RVALID is held until RREADY=1. A new AR is accepted no earlier than the cycle after the R handshake.
- Unmapped addresses (index 5-7, or upper address bits set): write is ignored with BRESP=SLVERR (2'b10); read returns RDATA=0 with RRESP=SLVERR. Mapped accesses return OKAY.
- core_start:
  - It pulses exactly one cycle, the cycle after the commit of a CTRL write with WSTRB[0]=1, WDATA[0]=1 and core_busy=0.
  - START while core_busy=1 is ignored: no pulse, write still OKAY.
- DONE:
  - core_done=1 sets DONE.
  - A W1C on DONE in the same cycle as core_done keeps DONE=1 (set wins).
- irq = DONE & IRQ_EN, registered, so 1-cycle latency.
- Simultaneous read and write to the same register: the read returns the value before the write commit.
- ARESETN asserted mid-transaction: all channels abort to the reset state immediately; a pending response is dropped.

Optional Feature:
- Macro: EDGE_DET_AXIL_CYCLE_CNT_EN.
- Defined: 0x10 CYCLE_CNT is RO.
  - Cleared to 0 on the core_start pulse.
  - Increments by 1 each cycle core_busy=1.
  - Saturates at 0xFFFFFFFF.
  - Writes to it get OKAY and are ignored.
- Undefined: 0x10 is unmapped and returns SLVERR; no counter logic exists.

Test Plan:
- Write 0x00000001..0x00000004 to 0x00,0x04,0x08,0x0C, then read all four -> reads 0x00000000, 0x00000002, 0x00000003, 0x00000000 (CTRL START reads 0; THRESH holds 0x02; IMG_SIZE holds 0x03; DONE writes are W1C and BUSY is RO with core_busy=0); exactly one core_start pulse; all responses OKAY.
- W presented 3 cycles before AW, then BREADY held low for 5 cycles -> single commit; BVALID stays high for 5 cycles; AWREADY/WREADY stay 0 until the B handshake.
- Write 0x12345678 to 0x08, then write 0xFFFFFFFF with WSTRB=4'b0100 -> read gives 0x12FF5678; core_width=0x5678; core_height=0x12FF.
- Set IRQ_EN, pulse core_done -> STATUS reads 0x2 and irq=1 one cycle later. Write 0x2 to 0x0C in the same cycle as another core_done -> DONE stays 1. A later W1C with no core_done -> DONE=0, irq=0.
- Read 0x14 and write 0x1C -> RRESP=BRESP=2'b10, RDATA=0, no register changes. Read 0x10 -> SLVERR without the macro; with the macro, after start and 7 busy cycles it reads 7.
- Assert ARESETN low while RVALID=1 with RREADY=0 -> RVALID=0 immediately; all registers read 0 after reset release.

Source files
------------

// File: rtl/edge_det_axil_regs.sv
// AXI4-Lite register file for the edge-detection core: config, start pulse, sticky DONE, irq.
// Optional cycle counter at 0x10 is enabled by defining EDGE_DET_AXIL_CYCLE_CNT_EN.
module edge_det_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic [7:0]                      core_threshold,
  output logic [15:0]                     core_width,
  output logic [15:0]                     core_height,
  input  logic                            core_busy,
  input  logic                            core_done,
  output logic                            irq
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
  localparam logic [2:0] MaxIdx = 3'd4;
`else
  localparam logic [2:0] MaxIdx = 3'd3;
`endif

  function automatic logic addr_mapped(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return ((a >> 5) == '0) && (a[4:2] <= MaxIdx);
  endfunction

  logic        ready_en_q;
  logic        aw_valid_q, w_valid_q, bvalid_q, rvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0] w_data_q, rdata_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  thresh_q, thresh_d;
  logic [31:0] img_size_q, img_size_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        irq_q;
`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  logic        aw_ready, w_ready, ar_ready;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_commit, wr_ok, rd_ok;
  logic [31:0] rd_data;

  // Readiness is held low until the first clock after reset release.
  assign aw_ready  = ready_en_q && !aw_valid_q && !bvalid_q;
  assign w_ready   = ready_en_q && !w_valid_q && !bvalid_q;
  assign ar_ready  = ready_en_q && !rvalid_q;
  assign aw_hs     = S_AXI_AWVALID && aw_ready;
  assign w_hs      = S_AXI_WVALID && w_ready;
  assign ar_hs     = S_AXI_ARVALID && ar_ready;
  assign wr_commit = aw_valid_q && w_valid_q;
  assign wr_ok     = addr_mapped(aw_addr_q);
  assign rd_ok     = addr_mapped(S_AXI_ARADDR);

  always_comb begin
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    img_size_d = img_size_q;
    done_d     = done_q | core_done;
    start_d    = 1'b0;
    if (wr_commit && wr_ok) begin
      case (aw_addr_q[4:2])
        3'd0: if (w_strb_q[0]) begin
          irq_en_d = w_data_q[1];
          start_d  = w_data_q[0] & ~core_busy;
        end
        3'd1: if (w_strb_q[0]) thresh_d = w_data_q[7:0];
        3'd2: begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) img_size_d[8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
        // A coincident core_done wins over the clear.
        3'd3: if (w_strb_q[0] && w_data_q[1] && !core_done) done_d = 1'b0;
        default: ;
      endcase
    end
  end

`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (start_q) cnt_d = '0;
    else if (core_busy && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end
`endif

  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      case (S_AXI_ARADDR[4:2])
        3'd0: rd_data = {30'b0, irq_en_q, 1'b0};
        3'd1: rd_data = {24'b0, thresh_q};
        3'd2: rd_data = img_size_q;
        3'd3: rd_data = {30'b0, done_q, core_busy};
`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
        3'd4: rd_data = cnt_q;
`endif
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
      img_size_q <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      if (aw_hs) begin
        aw_valid_q <= 1'b1;
        aw_addr_q  <= S_AXI_AWADDR;
      end else if (wr_commit) begin
        aw_valid_q <= 1'b0;
      end
      if (w_hs) begin
        w_valid_q <= 1'b1;
        w_data_q  <= S_AXI_WDATA;
        w_strb_q  <= S_AXI_WSTRB;
      end else if (wr_commit) begin
        w_valid_q <= 1'b0;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RespOkay : RespSlvErr;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_ok ? RespOkay : RespSlvErr;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      img_size_q <= img_size_d;
      done_q     <= done_d;
      start_q    <= start_d;
      irq_q      <= done_q & irq_en_q;
`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_AWREADY  = aw_ready;
  assign S_AXI_WREADY   = w_ready;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_ARREADY  = ar_ready;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = rresp_q;
  assign core_start     = start_q;
  assign core_threshold = thresh_q;
  assign core_width     = img_size_q[15:0];
  assign core_height    = img_size_q[31:16];
  assign irq            = irq_q;

endmodule

// File: tb/tb_edge_det_axil_regs.sv
// Directed bench for edge_det_axil_regs; read/write responses checked through a scoreboard.
module tb_edge_det_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        core_start, core_busy, core_done, irq;
  logic [7:0]  core_threshold;
  logic [15:0] core_width, core_height;

  edge_det_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .core_start(core_start), .core_threshold(core_threshold),
    .core_width(core_width), .core_height(core_height),
    .core_busy(core_busy), .core_done(core_done), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int exp_starts = 0;
  logic [31:0] rdata_exp_q[$];
  logic [1:0]  rresp_exp_q[$];
  logic [1:0]  bresp_exp_q[$];

  always @(negedge ACLK) if (core_start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er);
    logic ar, wr, aw_done, w_done;
    logic [1:0] eb;
    int n;
    bresp_exp_q.push_back(er);
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      ar = S_AXI_AWREADY; wr = S_AXI_WREADY;
      @(posedge ACLK); #1; n++;
      if (ar && S_AXI_AWVALID) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (wr && S_AXI_WVALID)  begin S_AXI_WVALID = 1'b0;  w_done = 1'b1;  end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (!(aw_done && w_done)) chk("aw_w_accept", {31'b0, aw_done && w_done}, 32'd1);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    eb = bresp_exp_q.pop_front();
    if (S_AXI_BVALID) begin
      chk("bresp", {30'b0, S_AXI_BRESP}, {30'b0, eb});
      @(posedge ACLK); #1;
    end else begin
      chk("b_timeout", {31'b0, S_AXI_BVALID}, 32'd1);
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    logic r, done;
    logic [31:0] e_d;
    logic [1:0]  e_r;
    int n;
    rdata_exp_q.push_back(ed);
    rresp_exp_q.push_back(er);
    done = 1'b0; n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!done && n < 20) begin
      r = S_AXI_ARREADY;
      @(posedge ACLK); #1; n++;
      if (r) begin S_AXI_ARVALID = 1'b0; done = 1'b1; end
    end
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    e_d = rdata_exp_q.pop_front();
    e_r = rresp_exp_q.pop_front();
    if (S_AXI_RVALID) begin
      chk($sformatf("rdata@%02h", a), S_AXI_RDATA, e_d);
      chk($sformatf("rresp@%02h", a), {30'b0, S_AXI_RRESP}, {30'b0, e_r});
      @(posedge ACLK); #1;
    end else begin
      chk("r_timeout", {31'b0, S_AXI_RVALID}, 32'd1);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    core_busy = 1'b0; core_done = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
    chk("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
    chk("rst_valids", {29'b0, S_AXI_BVALID, S_AXI_RVALID, irq}, 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    ARESETN = 1'b1;

    // Basic map: START reads 0, DONE is W1C, BUSY is RO.
    axi_write(5'h00, 32'h1, 4'hF, 2'b00); exp_starts++;
    axi_write(5'h04, 32'h2, 4'hF, 2'b00);
    axi_write(5'h08, 32'h3, 4'hF, 2'b00);
    axi_write(5'h0C, 32'h4, 4'hF, 2'b00);
    axi_read(5'h00, 32'h0, 2'b00);
    axi_read(5'h04, 32'h2, 2'b00);
    axi_read(5'h08, 32'h3, 2'b00);
    axi_read(5'h0C, 32'h0, 2'b00);
    chk("start_count_1", start_cnt, exp_starts);
    chk("core_threshold", {24'b0, core_threshold}, 32'h2);

    // START while busy is ignored; BUSY visible in STATUS.
    core_busy = 1'b1;
    axi_read(5'h0C, 32'h1, 2'b00);
    axi_write(5'h00, 32'h1, 4'hF, 2'b00);
    core_busy = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("start_ignored_busy", start_cnt, exp_starts);

    // W three cycles before AW, B held off for five cycles.
    S_AXI_BREADY = 1'b0;
    S_AXI_WDATA = 32'hAB; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    chk("wready_idle", {31'b0, S_AXI_WREADY}, 32'd1);
    @(posedge ACLK); #1; S_AXI_WVALID = 1'b0;
    @(posedge ACLK); #1;
    chk("wready_latched", {30'b0, S_AXI_WREADY, S_AXI_AWREADY}, 32'h1);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1; S_AXI_AWVALID = 1'b0;
    @(posedge ACLK); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bhold_%0d", i),
          {28'b0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, 1'b0} | {30'b0, S_AXI_BRESP},
          32'h8);
      if (i < 4) begin @(posedge ACLK); #1; end
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    chk("b_released", {29'b0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
    axi_read(5'h04, 32'hAB, 2'b00);

    // Byte-lane write.
    axi_write(5'h08, 32'h12345678, 4'hF, 2'b00);
    axi_write(5'h08, 32'hFFFFFFFF, 4'b0100, 2'b00);
    axi_read(5'h08, 32'h12FF5678, 2'b00);
    chk("core_width", {16'b0, core_width}, 32'h5678);
    chk("core_height", {16'b0, core_height}, 32'h12FF);

    // DONE / irq.
    axi_write(5'h00, 32'h2, 4'hF, 2'b00);
    core_done = 1'b1;
    @(posedge ACLK); #1;
    core_done = 1'b0;
    chk("irq_latency0", {31'b0, irq}, 32'd0);
    @(posedge ACLK); #1;
    chk("irq_set", {31'b0, irq}, 32'd1);
    axi_read(5'h0C, 32'h2, 2'b00);
    core_done = 1'b1;
    axi_write(5'h0C, 32'h2, 4'hF, 2'b00);
    core_done = 1'b0;
    axi_read(5'h0C, 32'h2, 2'b00);
    axi_write(5'h0C, 32'h2, 4'hF, 2'b00);
    axi_read(5'h0C, 32'h0, 2'b00);
    chk("irq_cleared", {31'b0, irq}, 32'd0);

    // Unmapped accesses.
    axi_read(5'h14, 32'h0, 2'b10);
    axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 2'b10);
    axi_read(5'h00, 32'h2, 2'b00);
    axi_read(5'h04, 32'hAB, 2'b00);
    axi_read(5'h08, 32'h12FF5678, 2'b00);
`ifdef EDGE_DET_AXIL_CYCLE_CNT_EN
    axi_write(5'h00, 32'h3, 4'hF, 2'b00); exp_starts++;
    core_busy = 1'b1;
    repeat (7) @(posedge ACLK);
    #1;
    core_busy = 1'b0;
    axi_read(5'h10, 32'd7, 2'b00);
    axi_write(5'h10, 32'h55, 4'hF, 2'b00);
    axi_read(5'h10, 32'd7, 2'b00);
`else
    axi_read(5'h10, 32'h0, 2'b10);
    axi_write(5'h10, 32'h55, 4'hF, 2'b10);
`endif
    chk("start_count_final", start_cnt, exp_starts);

    // Reset while R is pending.
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1; S_AXI_ARVALID = 1'b0;
    @(posedge ACLK); #1;
    chk("rvalid_pending", {31'b0, S_AXI_RVALID}, 32'd1);
    ARESETN = 1'b0;
    #1;
    chk("rvalid_async_rst", {31'b0, S_AXI_RVALID}, 32'd0);
    chk("core_cfg_rst", {core_width, core_height}, 32'h0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    S_AXI_RREADY = 1'b1;
    axi_read(5'h00, 32'h0, 2'b00);
    axi_read(5'h04, 32'h0, 2'b00);
    axi_read(5'h08, 32'h0, 2'b00);
    axi_read(5'h0C, 32'h0, 2'b00);
    chk("sb_empty", rdata_exp_q.size() + rresp_exp_q.size() + bresp_exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
